// File: rtl/pitch_buffer_reader_if.sv
// Sample stream from the capture-buffer reader to the pitch estimator.
// Valid/ready; m_last marks the final sample of a round.
interface pitch_buffer_reader_if #(
    parameter int DATA_W = 12
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/pitch_buffer_reader.sv
// Streams one full ping-pong buffer per round to the estimator; first m_valid 2 clk after start_round.
// Reads are throttled so FIFO plus in-flight never exceeds 2; f0_done drops until stream drained and est_done seen.
module pitch_buffer_reader #(
    parameter int DEPTH_LOG2 = 11,
    parameter int DATA_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_round,
    input  logic                  now_writing,
    output logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [1:0]            rd_en,
    input  logic [DATA_W-1:0]     rdata0,
    input  logic [DATA_W-1:0]     rdata1,
    pitch_buffer_reader_if.master m,
    input  logic                  est_done,
    output logic                  f0_done,
    output logic                  overrun
);
    typedef enum logic [1:0] {IDLE, READ, WAIT_EST} state_t;

    localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

    state_t                state;
    logic [DEPTH_LOG2:0]   issue_cnt;
    logic [DEPTH_LOG2:0]   acc_cnt;
    logic                  est_seen;
    logic                  rd_sel;
    logic                  rd_sel_d;
    logic                  inflight;
    logic                  inflight_last;

    // Two-entry output FIFO: head drives the stream directly, tail absorbs one stall.
    logic                  h_vld, h_last, t_vld, t_last;
    logic [DATA_W-1:0]     h_dat, t_dat;

    logic                  pop;
    logic                  issue;
    logic [2:0]            used;
    logic [DATA_W-1:0]     push_dat;

    always_comb begin
        pop      = h_vld & m.m_ready;
        used     = {2'b00, h_vld} + {2'b00, t_vld} + {2'b00, inflight} - {2'b00, pop};
        issue    = (state == READ) && !issue_cnt[DEPTH_LOG2] && (used < 3'd2);
        push_dat = rd_sel_d ? rdata1 : rdata0;
    end

    assign rd_en     = issue ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    assign rd_addr   = issue_cnt[DEPTH_LOG2-1:0];
    assign m.m_data  = h_dat;
    assign m.m_valid = h_vld;
    assign m.m_last  = h_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            f0_done   <= 1'b1;
            overrun   <= 1'b0;
            rd_sel    <= 1'b0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            est_seen  <= 1'b0;
        end else begin
            if (start_round && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_round) begin
                        rd_sel    <= now_writing;
                        issue_cnt <= '0;
                        acc_cnt   <= '0;
                        est_seen  <= 1'b0;
                        state     <= READ;
                        f0_done   <= 1'b0;
                    end
                end
                READ: begin
                    if (issue)
                        issue_cnt <= issue_cnt + CNT_ONE;
                    if (pop)
                        acc_cnt <= acc_cnt + CNT_ONE;
                    if (est_done)
                        est_seen <= 1'b1;
                    if (pop && h_last) begin
                        if (est_seen || est_done) begin
                            state   <= IDLE;
                            f0_done <= 1'b1;
                        end else begin
                            state   <= WAIT_EST;
                        end
                    end
                end
                WAIT_EST: begin
                    if (est_done) begin
                        state   <= IDLE;
                        f0_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    f0_done <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_sel_d      <= 1'b0;
            h_vld         <= 1'b0;
            h_last        <= 1'b0;
            h_dat         <= '0;
            t_vld         <= 1'b0;
            t_last        <= 1'b0;
            t_dat         <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issue_cnt[DEPTH_LOG2-1:0] == '1);
            rd_sel_d      <= rd_sel;
            if (pop) begin
                if (t_vld) begin
                    h_dat  <= t_dat;
                    h_last <= t_last;
                    if (inflight) begin
                        t_dat  <= push_dat;
                        t_last <= inflight_last;
                    end else begin
                        t_vld  <= 1'b0;
                    end
                end else if (inflight) begin
                    h_dat  <= push_dat;
                    h_last <= inflight_last;
                end else begin
                    h_vld  <= 1'b0;
                end
            end else if (inflight) begin
                if (!h_vld) begin
                    h_vld  <= 1'b1;
                    h_dat  <= push_dat;
                    h_last <= inflight_last;
                end else begin
                    t_vld  <= 1'b1;
                    t_dat  <= push_dat;
                    t_last <= inflight_last;
                end
            end
        end
    end
endmodule

// File: doc/pitch_buffer_reader.md
# pitch_buffer_reader

Read side of the 2048-sample ping-pong capture buffer. On each `start_round` pulse from the sampler/writer, it latches which buffer has just been filled. It then streams all 2048 samples from that buffer to the pitch estimator over a valid/ready interface. It holds `f0_done` low until both the stream has drained and the estimator reports completion, which throttles the next capture round.

## Interface
- `DEPTH_LOG2`, 11, buffer address width; the buffer depth is 2^DEPTH_LOG2 = 2048.
- `DATA_W`, 12, sample width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low; clock `clk`.
- `start_round`  in  1  single-cycle pulse from the writer: the buffer is full and a new round begins.
- `now_writing`  in  1  writer's buffer-select register; sampled in the same cycle as `start_round`, so it carries the pre-toggle value.
- `rd_addr`  out  DEPTH_LOG2  BRAM read address, shared by both buffers.
- `rd_en`  out  2  read enable, one-hot: 2'b01 selects buffer 0, 2'b10 selects buffer 1, 2'b00 means idle.
- `rdata0`, `rdata1`  in  DATA_W  BRAM read data; valid 1 clk after the read is issued.
- `m_data`  out  DATA_W  sample presented to the estimator.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  estimator accepts the sample.
- `m_last`  out  1  high together with the sample at index 2047.
- `est_done`  in  1  pulse from the estimator: its f0 result is final.
- `f0_done`  out  1  level; reader and estimator are idle and the next round may start.
- `overrun`  out  1  sticky error flag; `start_round` arrived while the reader was not IDLE.

## Operation
- State machine: IDLE, READ, WAIT_EST.
- **IDLE**
  - `f0_done` = 1.
  - On `start_round`: `rd_sel` <= `now_writing`; `issue_cnt`, `acc_cnt` and the `est_seen` flag are cleared; next state is READ.
- **READ**
  - Reads are issued from the `rd_sel` buffer at addresses 0..2047 in order, one per clk, as long as space allows.
  - Space rule: a read is issued only when (FIFO occupancy − pop this cycle + in-flight reads) < 2. The 2-entry output FIFO therefore never overflows.
  - Returning data (`rdata0` or `rdata1`, chosen by the delayed `rd_sel`) is pushed into the FIFO.
  - `m_data`/`m_valid` come from the FIFO head.
  - A handshake (`m_valid` & `m_ready`) increments `acc_cnt`.
  - Once `issue_cnt` reaches 2048, no further reads are issued and `rd_en` = 00.
  - An `est_done` pulse during READ sets `est_seen`.
  - When the handshake with `m_last` completes: next state is IDLE if `est_seen` or `est_done` is high this cycle; otherwise WAIT_EST.
- **WAIT_EST**
  - `rd_en` = 00, `m_valid` = 0.
  - On `est_done`: next state is IDLE.
- `f0_done` = (state == IDLE). It is registered; no combinational path from any input.
- `rd_en` is always 00 outside READ, and always 00 once all reads are issued.
- `start_round` outside IDLE is ignored (state and counters unchanged) and sets `overrun`.
- `est_done` in IDLE is ignored.
- Counters are DEPTH_LOG2+1 bits wide so they can reach 2048 without wrap. `rd_addr` = `issue_cnt`[DEPTH_LOG2-1:0].
- `m_last` = FIFO head tag, set on the entry read from address 2047.
- A synchronous reset at any time forces IDLE, flushes the FIFO, clears the in-flight pipeline, and discards any pending `m_valid`.

## Timing
- Reset values: `rd_addr` = 0, `rd_en` = 00, `m_data` = 0, `m_valid` = 0, `m_last` = 0, `f0_done` = 1, `overrun` = 0, `rd_sel` = 0.
- Edge E0 samples `start_round`. Cycle E0–E1: `rd_en` active, `rd_addr` = 0. After E1: `rdata` is valid. After E2: `m_valid` = 1 with sample 0. Latency is 2 clk from the `start_round` edge to the first `m_valid`.
- With `m_ready` held high, throughput is 1 sample/clk. `m_last` is visible at E2049. `f0_done` rises 1 clk after the later of the last handshake and `est_done`.
- While `m_ready` = 0, `m_data`, `m_valid` and `m_last` hold stable. No sample is dropped or duplicated.
- The writer asserts `start_round` only while `f0_done` = 1, so a legal system never sets `overrun`.

## Test plan
- Reset, then idle for 10 clk -> `f0_done` = 1, `m_valid` = 0, `rd_en` = 00, `overrun` = 0 throughout.
- BRAM model with buffer0[a] = a, buffer1[a] = 0x800|a. `start_round` with `now_writing` = 0, `m_ready` = 1:
  - `rd_en` = 01 and `rd_addr` = 0..2047 on consecutive clk.
  - `m_valid` rises exactly 2 clk after `start_round`.
  - 2048 beats with `m_data` = 0x000..0x7FF, and `m_last` only on 0x7FF.
  - `f0_done` = 0 until `est_done`.
- Same stimulus with `now_writing` = 1 -> `rd_en` = 10, `m_data` = 0x800..0xFFF.
- Random `m_ready` (50% duty) -> exact in-order 2048-beat sequence; `m_data`/`m_valid` stable whenever stalled; FIFO occupancy never exceeds 2.
- `est_done` pulsed at beat 100 (inside READ) -> `f0_done` = 1 one clk after the `m_last` handshake. `est_done` pulsed 50 clk after `m_last` -> reader stays in WAIT_EST, `f0_done` = 1 one clk after `est_done`.
- `start_round` at beat 500 -> stream continues unchanged and `overrun` = 1 (sticky). `rst` = 0 at beat 800 -> next clk `m_valid` = 0, `rd_en` = 00, `f0_done` = 1, `overrun` = 0.
